int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_pkg.sv | 22 ++
 rtl/irq_sync.sv | 29 ++
 rtl/int_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_int_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg -- shared definitions for the interrupt controller slice.
//   Register byte offsets, mcause values for the three interrupt sources,
//   and the request FSM state encoding.
package int_ctrl_pkg;

  localparam logic [4:0] OFS_MSIP    = 5'h00;
  localparam logic [4:0] OFS_CMP_LO  = 5'h08;
  localparam logic [4:0] OFS_CMP_HI  = 5'h0C;
  localparam logic [4:0] OFS_TIME_LO = 5'h10;
  localparam logic [4:0] OFS_TIME_HI = 5'h14;

  localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
  localparam logic [31:0] CAUSE_SW  = 32'h8000_0003;
  localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

endpackage

// File: rtl/irq_sync.sv
// irq_sync -- two-flop synchronizer plus rising-edge detector for an
// asynchronous interrupt line.
//   clk      : sampling clock
//   rst      : asynchronous active-low reset
//   async_in : raw asynchronous request line
//   rise     : one-cycle pulse on a rising edge of the synchronized line
module irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_in};
      prev_q <= sync_q[1];
    end
  end

  assign rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl -- machine-level interrupt controller: mtime/mtimecmp timer,
// optional software interrupt (msip), synchronized external interrupt,
// fixed-priority arbiter and a request/acknowledge/blanking FSM.
//   Build option: define INT_CTRL_SWI_EN to include msip and the software
//   interrupt source; without it offset 0x00 reads 0 and ignores writes.
//   Parameters: PRESCALE  clk cycles per mtime tick (1..255)
//               BLANK_CYC cycles interrupt stays low after an acknowledge
//   Ports: clk, rst (async active-low), ext_irq_in (async external request),
//          bus_req/bus_we/bus_addr/bus_wdata -> bus_rdata/bus_rvalid
//          (register access, read data one cycle later),
//          int_ack (acknowledge pulse), interrupt (level request),
//          int_cause (mcause of the current request).
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE  = 4,
  parameter int unsigned BLANK_CYC = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_irq_in,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  input  logic        int_ack,
  output logic        interrupt,
  output logic [31:0] int_cause
);

  logic        wr, rd;
  logic [7:0]  pre_cnt;
  logic        tick;
  logic [63:0] mtime, mtimecmp;
  logic [31:0] rd_mux;
  logic        ext_rise, ext_pend, sw_pend, tmr_pend;
  logic        any_pend, cur_pend;
  logic [31:0] win_cause, cause_d;
  logic [7:0]  blank_cnt, blank_d;
  state_t      state, state_d;

  assign wr = bus_req & bus_we;
  assign rd = bus_req & ~bus_we;

  // Prescaler: mtime advances on the cycle the counter wraps to 0.
  assign tick = (pre_cnt == 8'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pre_cnt <= '0;
    else      pre_cnt <= tick ? '0 : pre_cnt + 8'd1;
  end

  // A write to either mtime half suppresses that cycle's increment entirely,
  // so no carry leaks into the half that was not written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime <= '0;
    end else if (wr && bus_addr == OFS_TIME_LO) begin
      mtime[31:0] <= bus_wdata;
    end else if (wr && bus_addr == OFS_TIME_HI) begin
      mtime[63:32] <= bus_wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtimecmp <= '1;
    end else if (wr && bus_addr == OFS_CMP_LO) begin
      mtimecmp[31:0] <= bus_wdata;
    end else if (wr && bus_addr == OFS_CMP_HI) begin
      mtimecmp[63:32] <= bus_wdata;
    end
  end

`ifdef INT_CTRL_SWI_EN
  logic msip;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              msip <= 1'b0;
    else if (wr && bus_addr == OFS_MSIP)   msip <= bus_wdata[0];
  end

  assign sw_pend = msip;
`else
  assign sw_pend = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (bus_addr)
`ifdef INT_CTRL_SWI_EN
      OFS_MSIP:    rd_mux = {31'd0, msip};
`endif
      OFS_CMP_LO:  rd_mux = mtimecmp[31:0];
      OFS_CMP_HI:  rd_mux = mtimecmp[63:32];
      OFS_TIME_LO: rd_mux = mtime[31:0];
      OFS_TIME_HI: rd_mux = mtime[63:32];
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_rvalid <= 1'b0;
      bus_rdata  <= '0;
    end else begin
      bus_rvalid <= rd;
      bus_rdata  <= rd ? rd_mux : '0;
    end
  end

  irq_sync u_irq_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ext_irq_in),
    .rise     (ext_rise)
  );

  // A fresh edge on the acknowledge cycle keeps the request pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ext_pend <= 1'b0;
    else if (ext_rise)
      ext_pend <= 1'b1;
    else if (state == ST_REQ && int_ack && int_cause == CAUSE_EXT)
      ext_pend <= 1'b0;
  end

  assign tmr_pend = (mtime >= mtimecmp);
  assign any_pend = ext_pend | sw_pend | tmr_pend;

  always_comb begin
    win_cause = CAUSE_TMR;
    if (ext_pend)     win_cause = CAUSE_EXT;
    else if (sw_pend) win_cause = CAUSE_SW;
  end

  always_comb begin
    cur_pend = 1'b0;
    case (int_cause)
      CAUSE_EXT: cur_pend = ext_pend;
      CAUSE_SW:  cur_pend = sw_pend;
      CAUSE_TMR: cur_pend = tmr_pend;
      default:   cur_pend = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      int_cause <= '0;
      blank_cnt <= '0;
    end else begin
      state     <= state_d;
      int_cause <= cause_d;
      blank_cnt <= blank_d;
    end
  end

  always_comb begin
    state_d   = state;
    cause_d   = int_cause;
    blank_d   = blank_cnt;
    interrupt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_pend) begin
          cause_d = win_cause;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        interrupt = 1'b1;
        if (int_ack) begin
          state_d = ST_BLANK;
          blank_d = 8'(BLANK_CYC);
        end else if (!cur_pend) begin
          state_d = ST_IDLE;
        end
      end
      ST_BLANK: begin
        if (blank_cnt <= 8'd1) begin
          blank_d = '0;
          state_d = ST_IDLE;
        end else begin
          blank_d = blank_cnt - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl -- directed self-checking bench for int_ctrl (PRESCALE=4,
// BLANK_CYC=3). Software-interrupt expectations follow INT_CTRL_SWI_EN.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ext_irq_in = 1'b0;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [4:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        int_ack = 1'b0;
  logic        interrupt;
  logic [31:0] int_cause;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  int_ctrl #(.PRESCALE(4), .BLANK_CYC(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .ext_irq_in (ext_irq_in),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .int_ack    (int_ack),
    .interrupt  (interrupt),
    .int_cause  (int_cause)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_wdata = data;
    @(posedge clk);
    #1 bus_req = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] addr, output logic [31:0] d, output logic v);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = addr;
    @(posedge clk);
    #1 bus_req = 1'b0;
    @(negedge clk);
    d = bus_rdata;
    v = bus_rvalid;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        v;
    bus_read(addr, d, v);
    check({tag, "_vld"}, 64'(v), 64'd1);
    check(tag, 64'(d), 64'(exp));
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    int_ack = 1'b1;
    @(posedge clk);
    #1 int_ack = 1'b0;
  endtask

  // Returns at a negedge once interrupt equals lvl or the budget runs out.
  task automatic wait_level(input logic lvl, input int budget, output int cyc);
    cyc = 0;
    while (interrupt !== lvl && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        v;
    int          cyc;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_irq",    64'(interrupt),  64'd0);
    check("rst_cause",  64'(int_cause),  64'd0);
    check("rst_rvalid", 64'(bus_rvalid), 64'd0);
    check("rst_rdata",  64'(bus_rdata),  64'd0);
    rst = 1'b1;

    rd_check("cmp_lo_rst", 5'h08, 32'hFFFF_FFFF);
    @(negedge clk);
    check("rvalid_drop", 64'(bus_rvalid), 64'd0);
    rd_check("cmp_hi_rst", 5'h0C, 32'hFFFF_FFFF);
    check("irq_idle", 64'(interrupt), 64'd0);
    rd_check("unmapped_rd", 5'h04, 32'h0);
    bus_write(5'h18, 32'hDEAD_BEEF);
    rd_check("unmapped_wr", 5'h18, 32'h0);

    // Timer interrupt at mtime = 10
    bus_write(5'h10, 32'h0);
    bus_write(5'h14, 32'h0);
    bus_write(5'h08, 32'h0000_000A);
    bus_write(5'h0C, 32'h0);
    wait_level(1'b1, 100, cyc);
    check("tmr_irq",   64'(interrupt), 64'd1);
    check("tmr_cause", 64'(int_cause), 64'h8000_0007);
    check("tmr_lat",   64'(cyc >= 30 && cyc <= 45), 64'd1);
    bus_read(5'h10, d, v);
    check("tmr_mtime", 64'(d == 32'd10 || d == 32'd11), 64'd1);
    ack_pulse();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("tmr_blank", 64'(interrupt), 64'd0);
    end
    wait_level(1'b1, 10, cyc);
    check("tmr_reassert", 64'(interrupt), 64'd1);
    check("tmr_cause2",   64'(int_cause), 64'h8000_0007);
    bus_write(5'h0C, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    check("tmr_cleared", 64'(interrupt), 64'd0);
    ack_pulse();
    @(negedge clk);
    check("ack_idle_ignored", 64'(interrupt), 64'd0);

    // External and software pending in the same cycle: ext_irq_in leads by
    // the synchronizer depth so ext_pend and msip are set on the same edge.
    @(negedge clk);
    ext_irq_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    bus_write(5'h00, 32'h1);
    ext_irq_in = 1'b0;
    wait_level(1'b1, 10, cyc);
    check("ext_first",       64'(interrupt), 64'd1);
    check("ext_first_cause", 64'(int_cause), 64'h8000_000B);
`ifdef INT_CTRL_SWI_EN
    rd_check("msip_rd", 5'h00, 32'h1);
`else
    rd_check("msip_rd", 5'h00, 32'h0);
`endif
    ack_pulse();
    wait_level(1'b1, 12, cyc);
`ifdef INT_CTRL_SWI_EN
    check("sw_second",       64'(interrupt), 64'd1);
    check("sw_second_cause", 64'(int_cause), 64'h8000_0003);
    bus_write(5'h00, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("sw_cleared", 64'(interrupt), 64'd0);
`else
    check("no_sw_irq", 64'(interrupt), 64'd0);
`endif

    // mtime wraps from all-ones to zero (high half first so a tick between
    // the writes cannot disturb the final value)
    bus_write(5'h14, 32'hFFFF_FFFF);
    bus_write(5'h10, 32'hFFFF_FFFF);
    repeat (6) @(negedge clk);
    rd_check("wrap_hi", 5'h14, 32'h0);
    bus_read(5'h10, d, v);
    check("wrap_lo", 64'(d <= 32'd3), 64'd1);
    check("wrap_irq_idle", 64'(interrupt), 64'd0);

    // New external edge on the acknowledge cycle
    @(negedge clk);
    ext_irq_in = 1'b1;
    repeat (3) @(negedge clk);
    ext_irq_in = 1'b0;
    wait_level(1'b1, 10, cyc);
    check("ext_a",       64'(interrupt), 64'd1);
    check("ext_a_cause", 64'(int_cause), 64'h8000_000B);
    repeat (3) @(negedge clk);
    ext_irq_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    ack_pulse();
    @(negedge clk);
    check("ext_a_blank", 64'(interrupt), 64'd0);
    ext_irq_in = 1'b0;
    wait_level(1'b1, 12, cyc);
    check("ext_b",       64'(interrupt), 64'd1);
    check("ext_b_cause", 64'(int_cause), 64'h8000_000B);
    ack_pulse();
    wait_level(1'b1, 12, cyc);
    check("ext_no_third", 64'(interrupt), 64'd0);

    // Reset asserted mid-request
    @(negedge clk);
    ext_irq_in = 1'b1;
    repeat (3) @(negedge clk);
    ext_irq_in = 1'b0;
    wait_level(1'b1, 10, cyc);
    check("pre_rst_irq", 64'(interrupt), 64'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_async_irq",   64'(interrupt),  64'd0);
    check("rst_async_cause", 64'(int_cause),  64'd0);
    check("rst_async_rvld",  64'(bus_rvalid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    rd_check("post_cmp_lo", 5'h08, 32'hFFFF_FFFF);
    rd_check("post_cmp_hi", 5'h0C, 32'hFFFF_FFFF);
    rd_check("post_time_hi", 5'h14, 32'h0);
    bus_read(5'h10, d, v);
    check("post_time_lo", 64'(d <= 32'd3), 64'd1);
    rd_check("post_msip", 5'h00, 32'h0);
    check("post_irq", 64'(interrupt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
